// File: rtl/in_port_pkg.sv
// Shared constants and helpers for the buffered input-port bank.
// Optional feature macro: IN_PORT_IRQ_EN (adds the irq output).
package in_port_pkg;

  localparam int unsigned IN_PORT_WIDTH    = 32;
  localparam int unsigned IN_PORT_CHANNELS = 4;
  localparam int unsigned IN_PORT_DEPTH    = 4;

  // Bus-mux select code that control drives to put InPort on the bus.
  localparam logic [4:0] BUS_SEL_IN_PORT = 5'b10110;

  // Number of bits needed to index 'value' distinct entries.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/in_port_fifo.sv
// Single-channel FIFO with occupancy count, used once per device channel.
// Optional feature macro: IN_PORT_IRQ_EN (adds the o_nonempty_next output).
module in_port_fifo
  import in_port_pkg::*;
#(
  parameter int unsigned WIDTH = IN_PORT_WIDTH,
  parameter int unsigned DEPTH = IN_PORT_DEPTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_nonempty
`ifdef IN_PORT_IRQ_EN
  ,
  output logic             o_nonempty_next
`endif
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Ready comes from the registered count only, so it never depends on a pop.
  assign w_push  = i_push_valid && !w_full;
  assign w_pop   = i_pop && !w_empty;

  assign o_push_ready = !w_full;
  assign o_nonempty   = !w_empty;
  assign o_head       = r_mem[r_rptr];

`ifdef IN_PORT_IRQ_EN
  // Occupancy after this edge is nonzero if a word lands or one survives the pop.
  assign o_nonempty_next = w_push || (!w_empty && !(w_pop && (r_count == CW'(1))));
`endif

  // Pointer and count bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage array; the word offered on a clear edge is discarded.
  always_ff @(posedge clock) begin
    if (w_push && !clear) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/in_port_bank.sv
// Multi-channel buffered input port: per-device FIFOs, registered pop mux
// onto the InPort bus-mux input, sticky underflow flags.
// Optional feature macro: IN_PORT_IRQ_EN (registered irq = any channel non-empty).
module in_port_bank
  import in_port_pkg::*;
#(
  parameter  int unsigned WIDTH    = IN_PORT_WIDTH,
  parameter  int unsigned CHANNELS = IN_PORT_CHANNELS,
  parameter  int unsigned DEPTH    = IN_PORT_DEPTH,
  localparam int unsigned SEL_W    = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [CHANNELS*WIDTH-1:0] dev_data,
  input  logic [CHANNELS-1:0]       dev_valid,
  output logic [CHANNELS-1:0]       dev_ready,
  input  logic                      rd_en,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      rd_valid,
  output logic [CHANNELS-1:0]       nonempty,
  output logic [CHANNELS-1:0]       underflow
`ifdef IN_PORT_IRQ_EN
  ,
  output logic                      irq
`endif
);

  logic [WIDTH-1:0]    w_heads [CHANNELS];
  logic [CHANNELS-1:0] w_nonempty;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_uf_set;
  logic [WIDTH-1:0]    w_head;
  logic                w_hit;

  logic [WIDTH-1:0]    r_bus;
  logic                r_valid;
  logic [CHANNELS-1:0] r_uf;

`ifdef IN_PORT_IRQ_EN
  logic [CHANNELS-1:0] w_ne_next;
  logic                r_irq;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    in_port_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clock          (clock),
      .clear          (clear),
      .i_push_data    (dev_data[g*WIDTH +: WIDTH]),
      .i_push_valid   (dev_valid[g]),
      .o_push_ready   (dev_ready[g]),
      .i_pop          (w_pop[g]),
      .o_head         (w_heads[g]),
      .o_nonempty     (w_nonempty[g])
`ifdef IN_PORT_IRQ_EN
      ,
      .o_nonempty_next(w_ne_next[g])
`endif
    );
  end

  // Pop mux: an out-of-range rd_sel matches no channel, so it pops nothing
  // and flags nothing.
  always_comb begin
    w_pop    = '0;
    w_uf_set = '0;
    w_head   = '0;
    w_hit    = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        w_head      = w_heads[i];
        w_hit       = w_nonempty[i];
        w_pop[i]    = rd_en;
        w_uf_set[i] = rd_en && !w_nonempty[i];
      end
    end
  end

  // Registered pop result and sticky underflow flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_bus   <= '0;
      r_valid <= 1'b0;
      r_uf    <= '0;
    end else begin
      r_valid <= rd_en && w_hit;
      if (rd_en && w_hit) begin
        r_bus <= w_head;
      end
      r_uf <= r_uf | w_uf_set;
    end
  end

`ifdef IN_PORT_IRQ_EN
  // Interrupt tracks whether any channel will hold data after this edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_ne_next;
    end
  end

  assign irq = r_irq;
`endif

  assign bus_out   = r_bus;
  assign rd_valid  = r_valid;
  assign nonempty  = w_nonempty;
  assign underflow = r_uf;

endmodule

// File: tb/tb_in_port_bank.sv
// Self-checking bench for in_port_bank (default parameters: 4 x 32-bit, depth 4).
// Reference model: one queue per channel plus expected output registers.
module tb_in_port_bank;

  localparam int CH = 4;
  localparam int DEPTH = 4;

  logic         clock;
  logic         clear;
  logic [127:0] dev_data;
  logic [3:0]   dev_valid;
  logic [3:0]   dev_ready;
  logic         rd_en;
  logic [1:0]   rd_sel;
  logic [31:0]  bus_out;
  logic         rd_valid;
  logic [3:0]   nonempty;
  logic [3:0]   underflow;
`ifdef IN_PORT_IRQ_EN
  logic         irq;
`endif

  in_port_bank #(
    .WIDTH(32),
    .CHANNELS(4),
    .DEPTH(4)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .dev_data (dev_data),
    .dev_valid(dev_valid),
    .dev_ready(dev_ready),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .bus_out  (bus_out),
    .rd_valid (rd_valid),
    .nonempty (nonempty),
    .underflow(underflow)
`ifdef IN_PORT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mq [CH][$];
  logic [31:0] m_bus = '0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_uf = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] word(input int c, input logic [31:0] val);
    logic [127:0] r;
    r = '0;
    r[c*32 +: 32] = val;
    return r;
  endfunction

  // One clock: drive inputs, advance the model, then compare on the falling edge.
  task automatic step(input logic clr, input logic [3:0] v, input logic [127:0] d,
                      input logic re, input logic [1:0] sel);
    logic [3:0] rdy;
    logic [3:0] exp_ne;
    logic [3:0] exp_rdy;
    clear = clr;
    dev_valid = v;
    dev_data = d;
    rd_en = re;
    rd_sel = sel;
    if (clr) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_bus = '0;
      m_valid = 1'b0;
      m_uf = '0;
    end else begin
      for (int c = 0; c < CH; c++) rdy[c] = (mq[c].size() != DEPTH);
      m_valid = 1'b0;
      if (re) begin
        if (mq[sel].size() > 0) begin
          m_bus = mq[sel].pop_front();
          m_valid = 1'b1;
        end else begin
          m_uf[sel] = 1'b1;
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (v[c] && rdy[c]) mq[c].push_back(d[c*32 +: 32]);
      end
    end
    @(posedge clock);
    @(negedge clock);
    for (int c = 0; c < CH; c++) begin
      exp_ne[c] = (mq[c].size() != 0);
      exp_rdy[c] = (mq[c].size() != DEPTH);
    end
    check("bus_out", bus_out, m_bus);
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("nonempty", 32'(nonempty), 32'(exp_ne));
    check("dev_ready", 32'(dev_ready), 32'(exp_rdy));
    check("underflow", 32'(underflow), 32'(m_uf));
`ifdef IN_PORT_IRQ_EN
    check("irq", 32'(irq), 32'(|exp_ne));
`endif
  endtask

  initial begin
    logic [127:0] rd;
    clear = 1'b1;
    dev_valid = '0;
    dev_data = '0;
    rd_en = 1'b0;
    rd_sel = '0;

    // Reset for two edges.
    step(1, 4'h0, '0, 0, 0);
    step(1, 4'h0, '0, 0, 0);
    check("reset_ready", 32'(dev_ready), 32'hF);
    check("reset_bus", bus_out, 32'h0);

    // Single word through channel 2.
    step(0, 4'b0100, word(2, 32'h77), 0, 0);
    check("single_ne", 32'(nonempty[2]), 32'd1);
    step(0, 4'h0, '0, 1, 2);
    check("single_bus", bus_out, 32'h77);
    check("single_valid", 32'(rd_valid), 32'd1);

    // Fill channel 0, then drain with pointer wrap while the device holds 0x14/0x15.
    for (int k = 0; k < 4; k++) step(0, 4'b0001, word(0, 32'h10 + k), 0, 0);
    check("full_ready", 32'(dev_ready[0]), 32'd0);
    step(0, 4'b0001, word(0, 32'h14), 1, 0);
    check("wrap_pop0", bus_out, 32'h10);
    step(0, 4'b0001, word(0, 32'h14), 1, 0);
    check("wrap_pop1", bus_out, 32'h11);
    step(0, 4'b0001, word(0, 32'h15), 1, 0);
    check("wrap_pop2", bus_out, 32'h12);
    for (int k = 3; k < 6; k++) begin
      step(0, 4'h0, '0, 1, 0);
      check("wrap_popN", bus_out, 32'h10 + k);
    end

    // Simultaneous push and pop on a non-empty channel.
    step(0, 4'b0010, word(1, 32'hA), 0, 0);
    step(0, 4'b0010, word(1, 32'hB), 1, 1);
    check("simul_bus", bus_out, 32'hA);
    check("simul_ne", 32'(nonempty[1]), 32'd1);
    step(0, 4'h0, '0, 1, 1);
    check("simul_second", bus_out, 32'hB);

    // Underflow on empty channel 3 with bus_out at 0x77.
    step(0, 4'b0100, word(2, 32'h77), 0, 0);
    step(0, 4'h0, '0, 1, 2);
    step(0, 4'h0, '0, 1, 3);
    check("uf_bus_hold", bus_out, 32'h77);
    check("uf_flag", 32'(underflow[3]), 32'd1);
    for (int k = 0; k < 3; k++) step(0, 4'h0, '0, 0, 0);
    check("uf_sticky", 32'(underflow[3]), 32'd1);

    // Push and pop on empty channel 0: no bypass.
    step(0, 4'b0001, word(0, 32'h55), 1, 0);
    check("nobypass_valid", 32'(rd_valid), 32'd0);
    step(0, 4'h0, '0, 1, 0);
    check("nobypass_bus", bus_out, 32'h55);

    // Clear mid-handshake discards the offered word.
    step(1, 4'hF, {4{32'hDEAD_BEEF}}, 1, 0);
    check("clear_uf", 32'(underflow), 32'd0);

`ifdef IN_PORT_IRQ_EN
    step(0, 4'b1000, word(3, 32'h1), 0, 0);
    check("irq_rise", 32'(irq), 32'd1);
    step(0, 4'h0, '0, 1, 3);
    check("irq_fall", 32'(irq), 32'd0);
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 63) == 0), 4'($urandom), rd,
           1'($urandom_range(0, 2) != 0), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/in_port_bank.md
# in_port_bank

Multi-channel, buffered successor to the single-register input port. Each of CHANNELS external devices pushes WIDTH-bit words into its own DEPTH-entry FIFO over a valid/ready handshake. The datapath pops one word per `in` instruction from the channel selected by the IR field and drives it, registered, onto the bus-mux input for InPort. Sticky underflow flags and an optional interrupt request report channel state to control logic.

## Interface
- WIDTH, 32, data word width
- CHANNELS, 4, number of device channels (1..16)
- DEPTH, 4, FIFO entries per channel (power of two, ≥2)
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-high reset
- dev_data  in  CHANNELS*WIDTH  device words; channel i occupies bits [i*WIDTH +: WIDTH]
- dev_valid  in  CHANNELS  device i offers dev_data word i
- dev_ready  out  CHANNELS  channel i FIFO not full
- rd_en  in  1  pop strobe from control (e_InPort timing)
- rd_sel  in  max(1,clog2(CHANNELS))  channel to pop
- bus_out  out  WIDTH  registered popped word, to BusMuxIn_InPort
- rd_valid  out  1  last rd_en returned real data
- nonempty  out  CHANNELS  per-channel FIFO count ≠ 0
- underflow  out  CHANNELS  sticky: pop attempted on empty channel
- irq  out  1  only when IN_PORT_IRQ_EN is defined

## Operation
- Push: on an edge with dev_valid[i] && dev_ready[i], the word is written at channel i's write pointer; count+1.
- dev_ready[i] = (count_i != DEPTH), derived from registered count only; never depends on rd_en.
- Pop: on an edge with rd_en, channel rd_sel:
  - non-empty: bus_out <= head word, read pointer +1, count−1, rd_valid <= 1.
  - empty, or rd_sel ≥ CHANNELS: bus_out holds its value, rd_valid <= 0, underflow[rd_sel] <= 1 (out-of-range index sets no flag).
- No rd_en: bus_out holds; rd_valid <= 0.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- Simultaneous push and pop on one non-empty channel: both occur, count unchanged; if full, the push is refused (dev_ready already 0).
- Push and pop on one empty channel: no bypass; pop underflows, push lands, count becomes 1.
- Different channels push independently in the same cycle.
- underflow[i] clears only on clear.
- clear at any point, including mid-handshake: all counts and pointers 0, bus_out 0, rd_valid 0, underflow 0, irq 0, dev_ready all 1 on the following cycle. The word offered on that edge is discarded.

## Timing
- Push-to-visible: a word pushed at edge k sets nonempty at k and is poppable by rd_en sampled at edge k+1.
- Pop latency: rd_en sampled at edge k → bus_out/rd_valid valid after edge k. Control asserts BusDataSelect=InPort in the following cycle, one state after e_InPort, matching the T3/T4 sequence of the `in` instruction.
- Full throughput: one push per channel per cycle plus one pop per cycle.

## Configuration
- IN_PORT_IRQ_EN defined: irq port exists and is registered. irq <= |nonempty_next, so it rises the edge after the first push into an empty bank and falls the edge after the last word is popped. Reset value 0.
- Undefined: no irq port, no related logic.

## Structure
- Shared package in_port_pkg: default WIDTH/CHANNELS/DEPTH constants, the InPort bus-select code 5'b10110, and a clog2 function for pointer widths.
- One sub-module, in_port_fifo (single-channel FIFO with count, push/pop, full/empty), generated CHANNELS times. The top holds the pop mux, bus_out/rd_valid registers, underflow flags and irq.

## Test plan
- Reset: clear high for 2 edges → bus_out=0, rd_valid=0, underflow=0, dev_ready=4'hF, nonempty=0.
- Single word: dev_data ch2=32'h00000077 with dev_valid[2] for one edge, then rd_en with rd_sel=2 → bus_out=32'h77, rd_valid=1, nonempty[2]=0.
- Fill/wrap: push 0x10..0x15 to ch0 with DEPTH=4 → dev_ready[0]=0 after the 4th push, and 0x14/0x15 are held until space frees. Then 6 pops return 0x10..0x15 in order, exercising pointer wrap.
- Simultaneous: ch1 holds 0xA. Same edge pushes 0xB and pops ch1 → bus_out=0xA, count stays 1. Next pop → 0xB.
- Underflow: rd_en on empty ch3 while bus_out=0x77 → bus_out stays 0x77, rd_valid=0, underflow[3]=1, which persists until clear.
- IRQ (IN_PORT_IRQ_EN defined): push one word into an empty bank → irq=1 after the next edge; pop it → irq=0 after the next edge.
